gomoku_board: RTL and testbench
===============================

# gomoku_board

Parametrised N×N gomoku board with sequential win detection. It stores stones and enforces move legality and turn order. After each accepted move it scans the lines through the new stone, one cell per clock. It sits between the keyboard/cursor controller (which drives `go`, `x`, `y`) and the VGA renderer (which reads cells through the read port and shows `state`).

## Interface
- `N`, default 7: board side length; legal range 5..15.
- `K`, default 5: stones in a row needed to win; legal range 3..N.
- `CW`, localparam, $clog2(N): coordinate width.

- `clk`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low.
- `go`  in  1: move request; sampled only while `ready`=1.
- `x`  in  CW: move row.
- `y`  in  CW: move column.
- `ready`  out  1: block is idle and can accept `go`.
- `accepted`  out  1: one-cycle pulse; the move was stored.
- `rejected`  out  1: one-cycle pulse; the move was illegal and the board is unchanged.
- `turn`  out  1: player to move; 0 = black, 1 = white.
- `state`  out  2: 0 = playing, 1 = black win, 2 = white win, 3 = draw.
- `move_count`  out  $clog2(N*N+1): number of stones on the board.
- `rd_x`  in  CW: read-port row.
- `rd_y`  in  CW: read-port column.
- `rd_cell`  out  2: contents of the addressed cell; 0 = empty, 1 = black, 2 = white.

## Operation
- Storage: N*N cells, 2 bits each, indexed N*x+y.
- FSM states: IDLE, SCAN, DONE, OVER.
- `ready` = (FSM state == IDLE), combinational.
- IDLE, `go`=1, move illegal: a move is illegal if x≥N, y≥N, or the target cell is non-empty. Pulse `rejected`; stay in IDLE.
- IDLE, `go`=1, move legal:
  - write `turn`+1 to the cell;
  - latch cx, cy and color = `turn`;
  - increment `move_count` and pulse `accepted`;
  - go to SCAN with dir=0, side=+, step=1, run=1.
- Scan directions: dir 0 = (0,+1), dir 1 = (+1,0), dir 2 = (+1,+1), dir 3 = (+1,−1). Side − negates the direction vector.
- SCAN examines one cell per cycle, at (cx+side·step·dx, cy+side·step·dy).
  - Coordinate arithmetic uses signed CW+2 bits.
  - Out of bounds counts as a mismatch.
- SCAN, cell matches color:
  - run+1; step+1.
  - If run+1 ≥ K: `state` ← color+1; go to OVER.
  - K or more in a row wins; overlines count.
- SCAN, mismatch:
  - side + → switch to side −, step=1;
  - side −, dir<3 → dir+1, side +, step=1, run=1;
  - side −, dir=3 → go to DONE.
- DONE, one cycle:
  - if `move_count` == N*N: `state` ← 3, go to OVER;
  - else toggle `turn`, go to IDLE.
- OVER: `ready`=0; `go` is ignored; board and `state` hold until reset.
- Read port: `rd_cell` is registered, 1-cycle latency. It returns 0 for rd_x≥N or rd_y≥N. It is independent of the FSM, and a same-cycle write is seen on the following read.

## Timing
- Reset values: all cells 0, FSM IDLE, `ready`=1, `accepted`=0, `rejected`=0, `turn`=0, `state`=0, `move_count`=0, `rd_cell`=0.
- `go` sampled at edge T with `ready`=1:
  - `accepted` or `rejected` is high during cycle T+1 only;
  - the cell is readable from T+1, with `rd_cell` valid at T+2.
- Accepted move:
  - `ready`=0 from T+1;
  - SCAN occupies at most 4K cycles;
  - DONE takes 1 cycle;
  - `ready` returns within 4K+2 cycles of T.
- Win: `state` changes on the edge that finds the K-th stone; DONE is skipped and `turn` does not toggle.
- `go` while `ready`=0 is dropped silently, with no pulse.
- `resetn` low at any time, including mid-SCAN, clears everything on that edge; the scan is abandoned.
- `x`/`y` only need to be stable on the edge where `go` is sampled.

## Test plan
- Reset, then black at (3,3) → `accepted` pulse at T+1; `rd_cell`(3,3)=1 at T+2; `turn`=1 and `state`=0 once `ready` returns.
- Play white at (3,3) after black occupies it → `rejected` pulse; `turn` unchanged; `move_count` unchanged. Move (7,0) with N=7 → `rejected`.
- Black (0,0)..(0,4), white on row 6 between them → `state`=1 within 4K+1 cycles of the 5th `go`; further `go` ignored and `ready` stays 0.
- Diagonal 3 (anti-diagonal) win for white, completed by a middle stone (K=5, stones at (1,5),(2,4),(4,2),(5,1) then (3,3)) → `state`=2.
- N=5, K=5: fill the board with no five-in-a-row → after the 25th move `state`=3 and `move_count`=25.
- Assert `resetn` low mid-SCAN → next cycle all cells 0, `state`=0, `turn`=0, `ready`=1.

Source files
------------

// File: rtl/gomoku_board.sv
// N x N gomoku board: stores stones, enforces legality and turn order, and
// after every accepted move walks the four lines through the new stone one cell per clock.
module gomoku_board #(
   parameter int N = 7,
   parameter int K = 5,
   localparam int CW = $clog2(N),
   localparam int MW = $clog2(N*N+1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          go,
   input  logic [CW-1:0] x,
   input  logic [CW-1:0] y,
   output logic          ready,
   output logic          accepted,
   output logic          rejected,
   output logic          turn,
   output logic [1:0]    state,
   output logic [MW-1:0] move_count,
   input  logic [CW-1:0] rd_x,
   input  logic [CW-1:0] rd_y,
   output logic [1:0]    rd_cell
);

   localparam int AW = $clog2(N*N);
   localparam int SW = CW + 2;
   localparam int RW = $clog2(K+1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE, OVER} fsm_t;

   fsm_t                 fsm, fsm_nx;
   logic [1:0]           cells [N*N];
   logic [CW-1:0]        cx, cy;
   logic                 color;
   logic [1:0]           dir;
   logic                 side;
   logic signed [SW-1:0] step;
   logic [RW-1:0]        run;

   logic                 legal, in_bounds, hit, win_now, full;
   logic [AW-1:0]        wr_addr, rd_addr, scan_addr;
   logic signed [SW-1:0] sstep, cxs, cys, px, py;

   assign ready   = (fsm == IDLE);
   assign wr_addr = AW'(N*int'(x) + int'(y));
   assign rd_addr = AW'(N*int'(rd_x) + int'(rd_y));
   assign legal   = (int'(x) < N) && (int'(y) < N) && (cells[wr_addr] == 2'd0);
   assign full    = (int'(move_count) == N*N);

   // Probe coordinate for the current direction/side/step; side '-' mirrors the vector.
   always_comb begin
      cxs   = SW'(cx);
      cys   = SW'(cy);
      sstep = side ? -step : step;
      px    = cxs;
      py    = cys;
      case (dir)
         2'd0: py = cys + sstep;
         2'd1: px = cxs + sstep;
         2'd2: begin px = cxs + sstep; py = cys + sstep; end
         default: begin px = cxs + sstep; py = cys - sstep; end
      endcase
      in_bounds = (px >= 0) && (py >= 0) && (px < SW'(N)) && (py < SW'(N));
      scan_addr = AW'(N*int'(px) + int'(py));
      hit       = in_bounds && (cells[scan_addr] == {color, ~color});
      win_now   = hit && (int'(run) + 1 >= K);
   end

   always_comb begin
      fsm_nx = fsm;
      case (fsm)
         IDLE: if (go && legal) fsm_nx = SCAN;
         SCAN: begin
            if (win_now)                          fsm_nx = OVER;
            else if (!hit && side && dir == 2'd3) fsm_nx = DONE;
         end
         DONE: fsm_nx = full ? OVER : IDLE;
         default: fsm_nx = OVER;
      endcase
   end

   // A cell written on one edge becomes visible to the read port on the next.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fsm        <= IDLE;
         for (int i = 0; i < N*N; i++) cells[i] <= 2'd0;
         cx         <= '0;
         cy         <= '0;
         color      <= 1'b0;
         dir        <= 2'd0;
         side       <= 1'b0;
         step       <= SW'(1);
         run        <= RW'(1);
         accepted   <= 1'b0;
         rejected   <= 1'b0;
         turn       <= 1'b0;
         state      <= 2'd0;
         move_count <= '0;
         rd_cell    <= 2'd0;
      end else begin
         fsm      <= fsm_nx;
         accepted <= 1'b0;
         rejected <= 1'b0;
         rd_cell  <= ((int'(rd_x) < N) && (int'(rd_y) < N)) ? cells[rd_addr] : 2'd0;
         case (fsm)
            IDLE: begin
               if (go) begin
                  if (legal) begin
                     cells[wr_addr] <= {turn, ~turn};
                     cx             <= x;
                     cy             <= y;
                     color          <= turn;
                     move_count     <= move_count + 1'b1;
                     accepted       <= 1'b1;
                     dir            <= 2'd0;
                     side           <= 1'b0;
                     step           <= SW'(1);
                     run            <= RW'(1);
                  end else begin
                     rejected <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (hit) begin
                  run  <= run + 1'b1;
                  step <= step + SW'(1);
                  if (win_now) state <= {color, ~color};
               end else if (!side) begin
                  side <= 1'b1;
                  step <= SW'(1);
               end else if (dir != 2'd3) begin
                  dir  <= dir + 1'b1;
                  side <= 1'b0;
                  step <= SW'(1);
                  run  <= RW'(1);
               end
            end
            DONE: begin
               if (full) state <= 2'd3;
               else      turn  <= ~turn;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gomoku_board.sv
// Self-checking bench for gomoku_board: directed games plus random play on a 7x7 board
// and a draw on a 5x5 board, all compared against a line-counting board model.
module tb_gomoku_board;

   localparam int K = 5;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] x, y, rd_x, rd_y;
   logic       go0, go1;

   logic       ready0, acc0, rej0, turn0;
   logic [1:0] state0, cell0;
   logic [5:0] cnt0;
   logic       ready1, acc1, rej1, turn1;
   logic [1:0] state1, cell1;
   logic [4:0] cnt1;

   int errors = 0;
   int checks = 0;

   int mb [2][15][15];
   int mturn [2];
   int mstate [2];
   int mcount [2];
   int mn [2] = '{7, 5};

   always #5 clk = ~clk;

   gomoku_board #(.N(7), .K(K)) u_dut7 (
      .clk(clk), .resetn(resetn), .go(go0), .x(x), .y(y),
      .ready(ready0), .accepted(acc0), .rejected(rej0), .turn(turn0),
      .state(state0), .move_count(cnt0), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(cell0)
   );

   gomoku_board #(.N(5), .K(K)) u_dut5 (
      .clk(clk), .resetn(resetn), .go(go1), .x(x), .y(y),
      .ready(ready1), .accepted(acc1), .rejected(rej1), .turn(turn1),
      .state(state1), .move_count(cnt1), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(cell1)
   );

   function automatic int get_ready(int s); return (s == 0) ? int'(ready0) : int'(ready1); endfunction
   function automatic int get_acc(int s);   return (s == 0) ? int'(acc0)   : int'(acc1);   endfunction
   function automatic int get_rej(int s);   return (s == 0) ? int'(rej0)   : int'(rej1);   endfunction
   function automatic int get_turn(int s);  return (s == 0) ? int'(turn0)  : int'(turn1);  endfunction
   function automatic int get_state(int s); return (s == 0) ? int'(state0) : int'(state1); endfunction
   function automatic int get_cnt(int s);   return (s == 0) ? int'(cnt0)   : int'(cnt1);   endfunction
   function automatic int get_cell(int s);  return (s == 0) ? int'(cell0)  : int'(cell1);  endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset(int s);
      for (int i = 0; i < 15; i++)
         for (int j = 0; j < 15; j++) mb[s][i][j] = 0;
      mturn[s] = 0; mstate[s] = 0; mcount[s] = 0;
   endfunction

   function automatic int model_run(int s, int px, int py, int dx, int dy, int c);
      int r = 0;
      int i = px + dx;
      int j = py + dy;
      while (i >= 0 && i < mn[s] && j >= 0 && j < mn[s] && mb[s][i][j] == c) begin
         r++; i += dx; j += dy;
      end
      return r;
   endfunction

   // Longest line through the new stone decides the win; a full board is a draw.
   function automatic int model_move(int s, int px, int py);
      int dxs [4] = '{0, 1, 1, 1};
      int dys [4] = '{1, 0, 1, -1};
      int c, len, win;
      if (px >= mn[s] || py >= mn[s] || mb[s][px][py] != 0) return 0;
      c = mturn[s] + 1;
      mb[s][px][py] = c;
      mcount[s]++;
      win = 0;
      for (int d = 0; d < 4; d++) begin
         len = 1 + model_run(s, px, py, dxs[d], dys[d], c) + model_run(s, px, py, -dxs[d], -dys[d], c);
         if (len >= K) win = 1;
      end
      if (win)                          mstate[s] = c;
      else if (mcount[s] == mn[s]*mn[s]) mstate[s] = 3;
      else                              mturn[s] ^= 1;
      return 1;
   endfunction

   function automatic int model_cell(int s, int px, int py);
      if (px >= mn[s] || py >= mn[s]) return 0;
      return mb[s][px][py];
   endfunction

   task automatic do_reset();
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset(0);
      model_reset(1);
   endtask

   task automatic applyStimulus(input int s, input int mx, input int my);
      int expa, cyc;
      x = 3'(mx); y = 3'(my); rd_x = 3'(mx); rd_y = 3'(my);
      if (s == 0) go0 = 1'b1; else go1 = 1'b1;
      @(posedge clk); #1;
      go0 = 1'b0; go1 = 1'b0;
      expa = model_move(s, mx, my);
      check("accepted", get_acc(s), expa);
      check("rejected", get_rej(s), 1 - expa);
      if (expa == 1) check("busy_after_accept", get_ready(s), 0);
      @(posedge clk); #1;
      check("readback", get_cell(s), model_cell(s, mx, my));
      check("pulse_one_cycle", get_acc(s) + get_rej(s), 0);
      cyc = 1;
      while (get_ready(s) == 0 && get_state(s) == 0 && cyc < 4*K + 2) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("settle_in_time", int'(cyc <= 4*K + 1), 1);
      checkOutput(s);
   endtask

   task automatic checkOutput(input int s);
      check("state", get_state(s), mstate[s]);
      check("turn", get_turn(s), mturn[s]);
      check("move_count", get_cnt(s), mcount[s]);
      check("ready", get_ready(s), (mstate[s] == 0) ? 1 : 0);
   endtask

   task automatic drop_go(input int s, input int mx, input int my);
      x = 3'(mx); y = 3'(my);
      if (s == 0) go0 = 1'b1; else go1 = 1'b1;
      @(posedge clk); #1;
      go0 = 1'b0; go1 = 1'b0;
      check("dropped_acc", get_acc(s), 0);
      check("dropped_rej", get_rej(s), 0);
      checkOutput(s);
   endtask

   task automatic read_check(input int s, input int rx, input int ry);
      rd_x = 3'(rx); rd_y = 3'(ry);
      @(posedge clk); #1;
      check("read_port", get_cell(s), model_cell(s, rx, ry));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bq [$];
      int wq [$];
      int mx, my;
      go0 = 1'b0; go1 = 1'b0; x = '0; y = '0; rd_x = '0; rd_y = '0;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset(0); model_reset(1);
      check("reset_ready", int'(ready0), 1);
      check("reset_acc", int'(acc0), 0);
      check("reset_rej", int'(rej0), 0);
      check("reset_cell", int'(cell0), 0);
      checkOutput(0);
      checkOutput(1);
      resetn = 1'b1;

      $display("[TB] first move and illegal moves");
      applyStimulus(0, 3, 3);
      applyStimulus(0, 3, 3);
      applyStimulus(0, 7, 0);
      applyStimulus(0, 0, 7);
      applyStimulus(0, 2, 3);

      $display("[TB] row win for black");
      do_reset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, i);
         if (i < 4) applyStimulus(0, 6, i);
      end
      check("row_win_state", int'(state0), 1);
      drop_go(0, 5, 5);
      drop_go(0, 4, 4);
      read_check(0, 5, 5);
      read_check(0, 0, 4);

      $display("[TB] anti-diagonal win for white");
      do_reset();
      applyStimulus(0, 0, 0); applyStimulus(0, 1, 5);
      applyStimulus(0, 0, 2); applyStimulus(0, 2, 4);
      applyStimulus(0, 6, 0); applyStimulus(0, 4, 2);
      applyStimulus(0, 6, 2); applyStimulus(0, 5, 1);
      applyStimulus(0, 6, 4); applyStimulus(0, 3, 3);
      check("anti_diag_state", int'(state0), 2);

      $display("[TB] 5x5 draw");
      do_reset();
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            if ((i % 2 == 0) == (j == 0 || j == 1 || j == 4)) bq.push_back(i*5 + j);
            else wq.push_back(i*5 + j);
         end
      for (int m = 0; m < 25; m++) begin
         if (m % 2 == 0) begin mx = bq[m/2] / 5; my = bq[m/2] % 5; end
         else            begin mx = wq[m/2] / 5; my = wq[m/2] % 5; end
         applyStimulus(1, mx, my);
      end
      check("draw_state", int'(state1), 3);
      check("draw_count", int'(cnt1), 25);
      drop_go(1, 0, 0);

      $display("[TB] random games");
      for (int g = 0; g < 3; g++) begin
         do_reset();
         for (int a = 0; a < 80 && mstate[0] == 0; a++)
            applyStimulus(0, $urandom_range(0, 7), $urandom_range(0, 7));
         for (int r = 0; r < 6; r++)
            read_check(0, $urandom_range(0, 7), $urandom_range(0, 7));
      end

      $display("[TB] reset during scan");
      do_reset();
      applyStimulus(0, 1, 1);
      applyStimulus(0, 2, 2);
      x = 3'd4; y = 3'd4; go0 = 1'b1;
      @(posedge clk); #1;
      go0 = 1'b0;
      check("mid_scan_busy", int'(ready0), 0);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset(0); model_reset(1);
      checkOutput(0);
      read_check(0, 1, 1);
      read_check(0, 2, 2);
      read_check(0, 4, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
